imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writes a program into the instruction memory that the controller fetches from.
//  Bytes arrive one at a time over a valid/ready handshake and are packed into 32-bit words.
//  Each word is written to consecutive imem addresses starting at 0.
//  When the whole program is written, run_en is asserted; it drives the controller's en input.
// PARAMETERS
//  ADDR_W  9   imem word-address width; matches the controller PC width
//  DATA_W  32  instruction width; must equal 4*8
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse; begins a load of load_len words
//  load_len    in   ADDR_W+1  word count, 0..2**ADDR_W; sampled on start
//  abort       in   1       synchronous cancel of any load in progress
//  byte_in     in   8       program byte
//  byte_valid  in   1       byte_in is valid
//  byte_ready  out  1       loader accepts a byte this cycle
//  mem_we      out  1       imem write strobe, 1 cycle per word
//  mem_addr    out  ADDR_W  imem word address
//  mem_wdata   out  DATA_W  imem write data
//  busy        out  1       load in progress (COLLECT or WRITE)
//  done        out  1       last load completed
//  run_en      out  1       processor enable; equals done
// BEHAVIOUR
//  Reset: every output is 0. State=IDLE, the byte counter is 0, the word counter is 0.
//  FSM states: IDLE, COLLECT, WRITE, DONE.
//   IDLE: start=1 and load_len=0 -> DONE, with no writes.
//         start=1 and load_len>0 -> COLLECT; latch load_len; mem_addr<=0; byte_cnt<=0.
//   COLLECT: byte_ready=1. A byte is accepted when byte_valid & byte_ready.
//            Little-endian packing: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
//            The 4th accepted byte moves the FSM to WRITE on the next edge.
//   WRITE: lasts 1 cycle. mem_we=1, mem_addr=current word index, byte_ready=0.
//          If index==len-1 -> DONE; otherwise index+1 and return to COLLECT.
//   DONE: done=1 and run_en=1, held until a new start or abort. busy=0.
//  Latency: if the last byte is accepted at cycle N, mem_we=1 at N+1 and done=1 at N+2.
//  mem_wdata and mem_addr are stable throughout the mem_we cycle.
//  Outside WRITE, mem_we=0 and the values on mem_addr/mem_wdata are don't-care.
//  byte_valid without byte_ready: the byte is not consumed. The sender holds it (standard valid/ready).
//  start while busy: ignored.
//  start in DONE: clears done and run_en and begins a new load.
//  abort (any state): next state IDLE. Any partial word is discarded; done and run_en are cleared.
//   abort takes priority over start and over byte acceptance in the same cycle.
//   An abort raised in the WRITE cycle does not suppress that cycle's mem_we.
//  load_len = 2**ADDR_W: addresses 0..511 are written. The word index must not wrap before DONE,
//   so the index counter is ADDR_W+1 bits wide.
//  Async reset mid-load: return to IDLE immediately; all outputs go to 0, including mem_we.
// TESTING
//  T1: start, len=1; bytes 78,56,34,12 sent back-to-back
//      -> one mem_we, addr 0, data 0x12345678; done=1 two cycles after the last byte.
//  T2: len=3, byte_valid toggled randomly
//      -> writes at addrs 0,1,2 in order; byte_ready=0 during each WRITE cycle; no bytes lost.
//  T3: len=0 -> no mem_we; done=1 and run_en=1 one cycle after start.
//  T4: len=2, abort after 6 bytes -> only addr 0 is written; state IDLE; run_en=0.
//      A following start with len=1 loads cleanly.
//  T5: rst_n dropped after 2 bytes of a len=2 load -> all outputs 0 with no clock edge needed.
//      A reload then writes addr 0 correctly.
//  T6: start pulsed during COLLECT -> ignored; original len honoured.
//      start in DONE -> run_en drops and a new load runs.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte stream into the loader and the word-write bus toward the instruction memory.
// Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both 1; the sender holds byte_in stable while byte_valid=1 and ready=0.
interface imem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to imem
// addresses 0..len-1, then raises run_en to let the controller fetch.
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              run_en,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  // One bit wider than the address so a full 2**ADDR_W load ends before wrapping.
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;

    if (abort) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (load_len == '0) begin
              state_d = DONE;
            end else begin
              state_d    = COLLECT;
              len_d      = load_len;
              idx_d      = '0;
              byte_cnt_d = '0;
            end
          end
        end
        COLLECT: begin
          if (bus.byte_valid) begin
            unique case (byte_cnt_q)
              2'd0: word_d[7:0]   = bus.byte_in;
              2'd1: word_d[15:8]  = bus.byte_in;
              2'd2: word_d[23:16] = bus.byte_in;
              2'd3: word_d[31:24] = bus.byte_in;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_d = WRITE;
          end
        end
        WRITE: begin
          if (idx_q == len_q - {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
            state_d = COLLECT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset zeroes them without a clock.
  assign bus.byte_ready = (state_q == COLLECT);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.mem_addr   = idx_q[ADDR_W-1:0];
  assign bus.mem_wdata  = word_q;
  assign busy           = (state_q == COLLECT) || (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign run_en         = done;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a behavioural load model checked every cycle,
// a word scoreboard fed with hand-computed words, and literal latency checks.
module tb_imem_loader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              abort = 1'b0;
  logic              busy, done, run_en;
  logic [1:0]        dbg_state;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len), .abort(abort),
    .bus(ifc.master), .busy(busy), .done(done), .run_en(run_en), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] last_addr = '0;
  int n_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load model: tracks bytes per word, words written, and completion.
  bit          m_active, m_pend, m_done;
  int          m_len, m_words;
  logic [7:0]  m_b[$];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_pend = 0; m_done = 0; m_len = 0; m_words = 0; m_b.delete();
    end else if (abort) begin
      m_active = 0; m_pend = 0; m_done = 0; m_b.delete();
    end else if (m_pend) begin
      m_pend = 0;
      m_words++;
      if (m_words == m_len) begin m_active = 0; m_done = 1; end
    end else if (m_active) begin
      if (ifc.byte_valid) begin
        m_b.push_back(ifc.byte_in);
        if (m_b.size() == 4) begin
          m_data = {m_b[3], m_b[2], m_b[1], m_b[0]};
          m_addr = m_words[ADDR_W-1:0];
          m_pend = 1;
          m_b.delete();
        end
      end
    end else if (start) begin
      m_len    = int'(load_len);
      m_words  = 0;
      m_done   = (load_len == '0);
      m_active = (load_len != '0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("byte_ready", ifc.byte_ready, m_active && !m_pend);
      check("mem_we", ifc.mem_we, m_pend);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("run_en", run_en, m_done);
      if (ifc.mem_we && m_pend) begin
        check("mem_addr", ifc.mem_addr, m_addr);
        check("mem_wdata", ifc.mem_wdata, m_data);
        if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
        else check("sb_word", ifc.mem_wdata, exp_q.pop_front());
        last_addr = ifc.mem_addr;
        n_writes++;
      end
    end
  end

  // Driver tasks: every task starts and ends 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1; load_len = len[ADDR_W:0];
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    ifc.byte_valid = 1'b0;
    step(gap);
    ifc.byte_in = b;
    ifc.byte_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = ifc.byte_ready;
      @(posedge clk); #1;
    end
    ifc.byte_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_byte_ready"}, ifc.byte_ready, 0);
    check({tag, "_mem_we"}, ifc.mem_we, 0);
    check({tag, "_mem_addr"}, ifc.mem_addr, 0);
    check({tag, "_mem_wdata"}, ifc.mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_run_en"}, run_en, 0);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    logic [31:0] w;
    ifc.byte_in = '0;
    ifc.byte_valid = 1'b0;
    #2;
    check_zero_outputs("reset");
    #10 rst_n = 1'b1;
    step(1);

    // T1: single word, back-to-back bytes, latency
    exp_q.push_back(32'h1234_5678);
    pulse_start(1);
    send_word(32'h1234_5678, 0);
    check("t1_we_after_last", ifc.mem_we, 1);
    check("t1_addr", ifc.mem_addr, 0);
    check("t1_data", ifc.mem_wdata, 32'h1234_5678);
    check("t1_done_early", done, 0);
    step(1);
    check("t1_done", done, 1);
    check("t1_run_en", run_en, 1);
    check("t1_sb_empty", exp_q.size(), 0);

    // T2: three words with random valid gaps
    wr0 = n_writes;
    pulse_start(3);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0102_0304);
    exp_q.push_back(32'hCAFE_F00D);
    send_word(32'hDEAD_BEEF, 2);
    send_word(32'h0102_0304, 2);
    send_word(32'hCAFE_F00D, 2);
    step(2);
    check("t2_done", done, 1);
    check("t2_writes", n_writes - wr0, 3);
    check("t2_last_addr", last_addr, 2);
    check("t2_sb_empty", exp_q.size(), 0);

    // T3: zero-length load completes one cycle after start
    pulse_start(0);
    check("t3_done", done, 1);
    check("t3_run_en", run_en, 1);
    check("t3_busy", busy, 0);

    // T4: abort mid second word
    wr0 = n_writes;
    pulse_start(2);
    check("t4_run_en_cleared", run_en, 0);
    exp_q.push_back(32'hA1B2_C3D4);
    send_word(32'hA1B2_C3D4, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_abort();
    check("t4_state_idle", dbg_state, 2'd0);
    check("t4_run_en", run_en, 0);
    check("t4_busy", busy, 0);
    check("t4_writes", n_writes - wr0, 1);
    check("t4_sb_empty", exp_q.size(), 0);
    exp_q.push_back(32'h5566_7788);
    pulse_start(1);
    send_word(32'h5566_7788, 1);
    step(1);
    check("t4_reload_done", done, 1);
    check("t4_reload_addr", last_addr, 0);

    // T5: asynchronous reset mid-load
    pulse_start(2);
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("t5_async");
    @(posedge clk); #1 rst_n = 1'b1;
    step(1);
    exp_q.push_back(32'h0BAD_C0DE);
    pulse_start(1);
    send_word(32'h0BAD_C0DE, 0);
    step(1);
    check("t5_reload_done", done, 1);
    check("t5_reload_addr", last_addr, 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // T6: start ignored while busy; start from DONE begins a new load
    wr0 = n_writes;
    pulse_start(2);
    exp_q.push_back(32'h1357_9BDF);
    exp_q.push_back(32'h2468_ACE0);
    send_byte(8'hDF, 0);
    send_byte(8'h9B, 0);
    pulse_start(1);
    send_byte(8'h57, 0);
    send_byte(8'h13, 0);
    check("t6_busy_after_w0", busy, 1);
    send_word(32'h2468_ACE0, 0);
    step(1);
    check("t6_done", done, 1);
    check("t6_writes", n_writes - wr0, 2);
    pulse_start(1);
    check("t6_run_en_drop", run_en, 0);
    check("t6_busy", busy, 1);
    exp_q.push_back(32'hFEDC_BA98);
    send_word(32'hFEDC_BA98, 1);
    step(1);
    check("t6_done2", done, 1);

    // T7: full-depth load, index must not wrap
    wr0 = n_writes;
    pulse_start(1 << ADDR_W);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      w = $urandom;
      exp_q.push_back(w);
      send_word(w, 0);
    end
    step(1);
    check("t7_done", done, 1);
    check("t7_writes", n_writes - wr0, 512);
    check("t7_last_addr", last_addr, 511);
    check("t7_sb_empty", exp_q.size(), 0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
